// File: rtl/mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// mips_fetch_stage
//
// Instruction fetch stage sitting between the mips_memory2 read port and the
// decode stage. It owns the fetch PC, issues single-word reads, buffers the
// returned words together with their PC in a small FIFO, and hands them to
// decode under a valid/stall handshake. Taken branches/jumps redirect the PC
// and throw away every wrong-path word, whether buffered or still returning.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   stall             decode cannot take the presented instruction
//   redirect_valid    load redirect_pc (word aligned) as the new fetch PC
//   redirect_pc       redirect target
//   mem_addr          read address (current fetch PC)
//   mem_enable        read request strobe
//   mem_rw            always 0 (read)
//   mem_access_size   always 2'b00 (single word)
//   mem_busy          memory refuses the request this cycle
//   mem_dout          read data, valid the cycle after a request is accepted
//   insn, insn_pc     FIFO head: instruction word and its address
//   insn_valid        FIFO head holds a valid instruction
// ---------------------------------------------------------------------------
module mips_fetch_stage #(
  parameter logic [31:0] START_ADDR = 32'h8002_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [1:0]  mem_access_size,
  input  logic        mem_busy,
  input  logic [31:0] mem_dout,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    REDIR
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] pc_req;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic        squash;

  logic [31:0] fifo_insn [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic redirect_take;
  logic accept;
  logic push;
  logic pop;

  // Redirects are ignored only in BOOT. Issue is throttled so that every
  // outstanding request already has a FIFO slot reserved for its data, which
  // is why a push can never hit a full FIFO.
  always_comb begin
    redirect_take = redirect_valid && (state != BOOT);
    mem_enable    = (state == FETCH) && !redirect_valid &&
                    ((int'(count) + int'(inflight)) < DEPTH);
    accept        = mem_enable && !mem_busy;
    push          = inflight && !squash && !redirect_take;
    pop           = insn_valid && !stall && !redirect_take;
  end

  always_comb begin
    mem_addr        = pc_req;
    mem_rw          = 1'b0;
    mem_access_size = 2'b00;
    insn            = fifo_insn[rd_ptr];
    insn_pc         = fifo_pc[rd_ptr];
    insn_valid      = (count != '0);
  end

  // A redirect while already in REDIR keeps us in the bubble so the new
  // target gets its own idle cycle before fetching resumes.
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = FETCH;
      FETCH:   if (redirect_valid) state_next = REDIR;
      REDIR:   state_next = redirect_valid ? REDIR : FETCH;
      default: state_next = BOOT;
    endcase
  end

  // The word returning in a redirect cycle is dropped simply by not pushing
  // it. squash covers a request that would still be outstanding after the
  // redirect edge; because issue is suppressed while redirect_valid is high,
  // that request cannot exist, but the flag keeps the drop rule explicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc_req      <= START_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_insn[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      state    <= state_next;
      inflight <= accept;

      if (accept) begin
        inflight_pc <= pc_req;
        pc_req      <= pc_req + 32'd4;
      end

      if (inflight && squash) begin
        squash <= 1'b0;
      end

      if (redirect_take) begin
        pc_req <= {redirect_pc[31:2], 2'b00};
        squash <= accept;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          fifo_insn[wr_ptr] <= mem_dout;
          fifo_pc[wr_ptr]   <= inflight_pc;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_stage
//
// Self-checking bench for mips_fetch_stage. A simple memory answers every
// accepted read one cycle later with a word derived from its address. A
// stream model tracks which PC decode must see next: every instruction
// consumed must carry that PC and its image word, a redirect moves the
// expected PC to the aligned target, and a reset moves it back to the boot
// address. Protocol rules (flush after redirect, hold under stall, stable
// request under mem_busy) are checked alongside.
// ---------------------------------------------------------------------------
module tb_mips_fetch_stage;

  localparam logic [31:0] START = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_access_size;
  logic        mem_busy;
  logic [31:0] mem_dout;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;

  mips_fetch_stage #(
    .START_ADDR(START),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem_addr(mem_addr),
    .mem_enable(mem_enable),
    .mem_rw(mem_rw),
    .mem_access_size(mem_access_size),
    .mem_busy(mem_busy),
    .mem_dout(mem_dout),
    .insn(insn),
    .insn_pc(insn_pc),
    .insn_valid(insn_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_pc    = START;
  logic        prev_rst  = 1'b1;
  logic        flush_chk = 1'b0;
  logic        hold_chk  = 1'b0;
  logic        busy_chk  = 1'b0;
  logic [31:0] held_pc   = '0;
  logic [31:0] held_insn = '0;
  logic [31:0] held_addr = '0;
  logic        acc       = 1'b0;
  logic [31:0] acc_addr  = '0;
  int          idle      = 0;
  int          idle_max  = 0;
  logic [31:0] seen_q[$];

  typedef struct {
    logic        stall;
    logic        busy;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[6];

  // Synthetic program image: each word is a fixed scramble of its address.
  function automatic logic [31:0] image(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2409_5A5A;
  endfunction

  function automatic logic [31:0] seenAt(input int i);
    if (i < seen_q.size()) return seen_q[i];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference stream model, evaluated once per cycle after inputs settle.
  task automatic modelStep();
    logic in_boot;
    logic redir;
    logic delivered;
    in_boot   = prev_rst;
    redir     = redirect_valid && !in_boot && !rst;
    delivered = 1'b0;

    if (flush_chk) checkOutput("flush_valid", 32'(insn_valid), 32'd0);
    if (hold_chk) begin
      checkOutput("hold_valid", 32'(insn_valid), 32'd1);
      checkOutput("hold_pc", insn_pc, held_pc);
      checkOutput("hold_insn", insn, held_insn);
    end
    if (busy_chk && !redirect_valid) begin
      checkOutput("busy_en", 32'(mem_enable), 32'd1);
      checkOutput("busy_addr", mem_addr, held_addr);
    end
    flush_chk = 1'b0;
    hold_chk  = 1'b0;
    busy_chk  = 1'b0;

    if (rst) begin
      exp_pc = START;
      idle   = 0;
    end else begin
      if (insn_valid && !stall && !redir) begin
        checkOutput("insn_pc", insn_pc, exp_pc);
        checkOutput("insn", insn, image(exp_pc));
        seen_q.push_back(insn_pc);
        exp_pc    = exp_pc + 32'd4;
        delivered = 1'b1;
      end
      if (redir) begin
        exp_pc    = {redirect_pc[31:2], 2'b00};
        flush_chk = 1'b1;
      end else if (insn_valid && stall) begin
        hold_chk  = 1'b1;
        held_pc   = insn_pc;
        held_insn = insn;
      end
      if (mem_enable && mem_busy) begin
        busy_chk  = 1'b1;
        held_addr = mem_addr;
      end
      if (!delivered && !stall) idle++;
      else idle = 0;
      if (idle > idle_max) idle_max = idle;
    end

    acc      = mem_enable && !mem_busy && !rst;
    acc_addr = mem_addr;
    prev_rst = rst;
  endtask

  // One cycle: memory answers the previous acceptance, new inputs are
  // driven at the falling edge, and the model samples 1 time unit later.
  task automatic applyStimulus(input logic r, input logic s, input logic rv,
                               input logic [31:0] rpc, input logic b);
    @(negedge clk);
    mem_dout       = acc ? image(acc_addr) : 32'hDEAD_BEEF;
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_busy       = b;
    #1;
    modelStep();
  endtask

  initial begin
    int waited;
    logic [31:0] a0;
    logic s, b, rv;
    logic [31:0] rpc;

    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_busy       = 1'b0;
    mem_dout       = '0;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h8002_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h8002_0000, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h8002_0004, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h8002_0008, 1'b1, 32'h8002_0000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h8002_0008, 1'b1, 32'h8002_0000};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h8002_0008, 1'b1, 32'h8002_0004};

    // Reset for two cycles, then check the reset-visible outputs.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rst_en", 32'(mem_enable), 32'd0);
    checkOutput("rst_addr", mem_addr, START);
    checkOutput("rst_insn", insn, 32'd0);
    checkOutput("rst_insn_pc", insn_pc, 32'd0);
    checkOutput("rst_valid", 32'(insn_valid), 32'd0);
    checkOutput("rst_rw", 32'(mem_rw), 32'd0);
    checkOutput("rst_size", 32'(mem_access_size), 32'd0);

    // Start-up timeline from the boot cycle onward.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, tbl[i].stall, 1'b0, 32'h0, tbl[i].busy);
      checkOutput($sformatf("tbl%0d_en", i), 32'(mem_enable), 32'(tbl[i].exp_en));
      checkOutput($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
      checkOutput($sformatf("tbl%0d_valid", i), 32'(insn_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) checkOutput($sformatf("tbl%0d_pc", i), insn_pc, tbl[i].exp_pc);
    end
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Decode stalls long enough for the buffer to fill and issue to stop.
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_full_en", 32'(mem_enable), 32'd0);
    checkOutput("stall_full_valid", 32'(insn_valid), 32'd1);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Memory busy while a request is pending: address must not move.
    waited = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    while (!mem_enable && waited < 10) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      waited++;
    end
    checkOutput("busy_req_seen", 32'(mem_enable), 32'd1);
    a0 = mem_addr;
    repeat (2) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("busy_hold_addr", mem_addr, a0);
    end
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect to an unaligned target while a read is in flight.
    waited = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    while (!acc && waited < 10) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      waited++;
    end
    checkOutput("inflight_seen", 32'(acc), 32'd1);
    seen_q.delete();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8002_0043, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("redir_flush", 32'(insn_valid), 32'd0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("redir_first_pc", seenAt(0), 32'h8002_0040);

    // Redirect near the top of the address space: PC wraps to zero.
    seen_q.delete();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (14) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_pc0", seenAt(0), 32'hFFFF_FFF8);
    checkOutput("wrap_pc1", seenAt(1), 32'hFFFF_FFFC);
    checkOutput("wrap_pc2", seenAt(2), 32'h0000_0000);

    // Redirect together with stall while the buffer is full.
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("full_en", 32'(mem_enable), 32'd0);
    checkOutput("full_valid", 32'(insn_valid), 32'd1);
    seen_q.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h8002_0100, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("full_flush", 32'(insn_valid), 32'd0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("full_redir_pc", seenAt(0), 32'h8002_0100);

    // Reset mid-stream with a response outstanding.
    waited = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    while (!acc && waited < 10) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      waited++;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("mid_rst_valid", 32'(insn_valid), 32'd0);
    checkOutput("mid_rst_addr", mem_addr, START);
    seen_q.delete();
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("mid_rst_first_pc", seenAt(0), START);

    // Random traffic against the stream model.
    repeat (400) begin
      s  = ($urandom_range(0, 99) < 30);
      b  = ($urandom_range(0, 99) < 25);
      rv = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 1) == 0) rpc = 32'h8002_0000 + 32'($urandom_range(0, 1023));
      else rpc = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      applyStimulus(1'b0, s, rv, rpc, b);
    end
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    checkOutput("liveness", 32'(idle_max > 40), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
